// File: rtl/fft_mdc_ctrl_param.sv
// Timing controller for an N-point radix-2 MDC FFT pipeline (N = 2**LOG2N).
// It produces per-stage enables, commutator selects and twiddle ROM
// addresses, and handles the input handshake, stalls, end-of-stream flush
// and output valid/frame markers.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   S_IDLE  | no stream active; counters cleared, waiting for a sample
//   S_RUN   | accepting samples; pipeline advances once per accepted sample
//   S_FLUSH | input closed; pipeline self-advances OUT_LAT times to drain
module fft_mdc_ctrl_param #(
  parameter int LOG2N   = 5,
  parameter int OUT_LAT = 32
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  input  logic                           in_last,
  output logic                           in_ready,
  output logic                           ce,
  output logic [LOG2N-2:0]               stage_en,
  output logic [LOG2N-2:0]               sw,
  output logic [(LOG2N-1)*(LOG2N-1)-1:0] tw_addr,
  output logic                           out_valid,
  output logic                           out_first,
  output logic                           busy
);

  localparam int N  = 1 << LOG2N;
  localparam int NS = LOG2N - 1;
  localparam int AW = LOG2N - 1;
  localparam int CW = LOG2N + 1;

  localparam logic [CW-1:0]    OUT_LAT_C = CW'(OUT_LAT);
  localparam logic [CW-1:0]    LAST_D    = CW'(OUT_LAT - 1);
  localparam logic [LOG2N-1:0] FIRST_K   = LOG2N'(OUT_LAT % N);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [LOG2N-1:0]    k_q, k_d;
  logic [CW-1:0]       f_q, f_d;
  logic [CW-1:0]       d_q, d_d;
  logic [NS-1:0]       en_q, en_d;
  logic [NS-1:0]       sw_q, sw_d;
  logic [NS*AW-1:0]    tw_q, tw_d;

  logic accept;
  logic ce_w;

  assign accept = in_valid && (state_q != S_FLUSH);
  assign ce_w   = accept || (state_q == S_FLUSH);

  // Next state and counters; everything holds unless the pipeline advances.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    f_d     = f_q;
    d_d     = d_q;
    en_d    = en_q;
    if (ce_w) begin
      k_d = k_q + 1'b1;
      if (f_q != OUT_LAT_C) f_d = f_q + 1'b1;
      for (int s = 0; s < NS; s++) begin
        if (f_q == CW'(N - (N >> (s + 1)) - 1)) en_d[s] = 1'b1;
      end
      case (state_q)
        S_IDLE: begin
          if (accept) state_d = in_last ? S_FLUSH : S_RUN;
        end
        S_RUN: begin
          if (accept && in_last) state_d = S_FLUSH;
        end
        S_FLUSH: begin
          if (d_q == LAST_D) begin
            state_d = S_IDLE;
            k_d     = '0;
            f_d     = '0;
            d_d     = '0;
            en_d    = '0;
          end else begin
            d_d = d_q + 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Commutator select and twiddle address for the sample index k_d, so the
  // registered copies always describe the sample currently being presented.
  always_comb begin
    logic [LOG2N-1:0] c;
    logic [LOG2N-1:0] cm;
    sw_d = '0;
    tw_d = '0;
    c    = '0;
    cm   = '0;
    for (int s = 0; s < NS; s++) begin
      c  = k_d - LOG2N'(N - (N >> (s + 1)));
      cm = (c & LOG2N'((N >> (s + 1)) - 1)) << s;
      if (en_d[s]) begin
        sw_d[s]            = c[LOG2N-2-s];
        tw_d[s*AW +: AW]   = cm[AW-1:0];
      end
    end
  end

  // State and counter registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      f_q     <= '0;
      d_q     <= '0;
      en_q    <= '0;
      sw_q    <= '0;
      tw_q    <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      f_q     <= f_d;
      d_q     <= d_d;
      en_q    <= en_d;
      sw_q    <= sw_d;
      tw_q    <= tw_d;
    end
  end

  assign in_ready  = (state_q != S_FLUSH);
  assign ce        = ce_w;
  assign stage_en  = en_q;
  assign sw        = sw_q;
  assign tw_addr   = tw_q;
  assign out_valid = ce_w && (f_q == OUT_LAT_C);
  assign out_first = out_valid && (k_q == FIRST_K);
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_fft_mdc_ctrl_param.sv
// Bench for fft_mdc_ctrl_param: two configurations (N=32/OUT_LAT=32 and
// N=16/OUT_LAT=20) share one stimulus stream and are compared every cycle
// against a sample-count based reference model.
module tb_fft_mdc_ctrl_param;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic in_last = 1'b0;

  always #5 clk = ~clk;

  logic        rdy0, ce0, ov0, of0, busy0;
  logic [3:0]  en0, sw0;
  logic [15:0] tw0;
  logic        rdy1, ce1, ov1, of1, busy1;
  logic [2:0]  en1, sw1;
  logic [8:0]  tw1;

  fft_mdc_ctrl_param #(.LOG2N(5), .OUT_LAT(32)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_last(in_last),
    .in_ready(rdy0), .ce(ce0), .stage_en(en0), .sw(sw0), .tw_addr(tw0),
    .out_valid(ov0), .out_first(of0), .busy(busy0)
  );

  fft_mdc_ctrl_param #(.LOG2N(4), .OUT_LAT(20)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_last(in_last),
    .in_ready(rdy1), .ce(ce1), .stage_en(en1), .sw(sw1), .tw_addr(tw1),
    .out_valid(ov1), .out_first(of1), .busy(busy1)
  );

  int n_chk = 0;
  int n_err = 0;

  // model: 0 idle, 1 run, 2 flush; adv = pipeline advances since frame start
  int mst[2];
  int madv[2];
  int mdc[2];
  int cnt_ov[2];
  int cnt_of[2];
  int cnt_nr[2];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h want=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_cfg(input int c, input int L, input int OL,
                           input logic o_rdy, input logic o_ce,
                           input logic [63:0] o_en, input logic [63:0] o_sw,
                           input logic [63:0] o_tw, input logic o_ov,
                           input logic o_of, input logic o_busy);
    int n, k, f, e, cc;
    logic acc, cev, ov;
    logic [63:0] en, swv, tw;
    n   = 1 << L;
    acc = in_valid && (mst[c] != 2);
    cev = acc || (mst[c] == 2);
    k   = madv[c] % n;
    f   = (madv[c] < OL) ? madv[c] : OL;
    en  = '0;
    swv = '0;
    tw  = '0;
    for (int s = 0; s < L - 1; s++) begin
      e = n - (n >> (s + 1));
      if (madv[c] >= e) begin
        en[s]  = 1'b1;
        cc     = (k - e + n) % n;
        swv[s] = ((cc >> (L - 2 - s)) & 1) != 0;
        tw     = tw | (64'((cc % (n >> (s + 1))) << s) << (s * (L - 1)));
      end
    end
    ov = cev && (f == OL);
    chk($sformatf("c%0d_in_ready", c), 64'(o_rdy), 64'(mst[c] != 2));
    chk($sformatf("c%0d_ce", c), 64'(o_ce), 64'(cev));
    chk($sformatf("c%0d_stage_en", c), o_en, en);
    chk($sformatf("c%0d_sw", c), o_sw, swv);
    chk($sformatf("c%0d_tw_addr", c), o_tw, tw);
    chk($sformatf("c%0d_out_valid", c), 64'(o_ov), 64'(ov));
    chk($sformatf("c%0d_out_first", c), 64'(o_of), 64'(ov && (k == OL % n)));
    chk($sformatf("c%0d_busy", c), 64'(o_busy), 64'(mst[c] != 0));
    if (o_ov) cnt_ov[c]++;
    if (o_of) cnt_of[c]++;
    if (!o_rdy) cnt_nr[c]++;
  endtask

  task automatic model_step(input int c, input int OL);
    logic acc;
    acc = in_valid && (mst[c] != 2);
    if (mst[c] == 2) begin
      madv[c]++;
      if (mdc[c] == OL - 1) begin
        mst[c] = 0; madv[c] = 0; mdc[c] = 0;
      end else begin
        mdc[c]++;
      end
    end else if (acc) begin
      madv[c]++;
      if (in_last) mst[c] = 2;
      else mst[c] = 1;
    end
  endtask

  task automatic check_all();
    check_cfg(0, 5, 32, rdy0, ce0, 64'(en0), 64'(sw0), 64'(tw0), ov0, of0, busy0);
    check_cfg(1, 4, 20, rdy1, ce1, 64'(en1), 64'(sw1), 64'(tw1), ov1, of1, busy1);
  endtask

  task automatic cyc(input logic v, input logic l);
    @(negedge clk);
    in_valid = v;
    in_last  = l;
    #1;
    check_all();
    model_step(0, 32);
    model_step(1, 20);
  endtask

  task automatic do_reset();
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    #2 rst_n = 1'b0;
    for (int c = 0; c < 2; c++) begin
      mst[c] = 0; madv[c] = 0; mdc[c] = 0;
    end
    #1;
    check_all();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic clear_counts();
    for (int c = 0; c < 2; c++) begin
      cnt_ov[c] = 0; cnt_of[c] = 0; cnt_nr[c] = 0;
    end
  endtask

  task automatic stream(input int nsamp, input int tail);
    for (int i = 1; i <= nsamp; i++) cyc(1'b1, i == nsamp);
    repeat (tail) cyc(1'b0, 1'b0);
  endtask

  task automatic check_stream_counts();
    chk("c0_ov_count", 64'(cnt_ov[0]), 64'd96);
    chk("c0_of_count", 64'(cnt_of[0]), 64'd3);
    chk("c0_flush_cycles", 64'(cnt_nr[0]), 64'd32);
    chk("c1_ov_count", 64'(cnt_ov[1]), 64'd96);
    chk("c1_of_count", 64'(cnt_of[1]), 64'd6);
    chk("c1_flush_cycles", 64'(cnt_nr[1]), 64'd20);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    clear_counts();
    do_reset();

    // fill with in_valid held high, a 5-cycle stall, then resume
    repeat (70) cyc(1'b1, 1'b0);
    repeat (5) cyc(1'b0, 1'b0);
    repeat (20) cyc(1'b1, 1'b0);

    // random gaps and random end-of-stream markers
    repeat (400) cyc($urandom_range(0, 9) < 7, $urandom_range(0, 29) == 0);
    repeat (60) cyc(1'b0, 1'b0);

    // single-sample stream: IDLE straight to FLUSH, then immediate restart
    cyc(1'b1, 1'b1);
    repeat (31) cyc(1'b0, 1'b0);
    repeat (10) cyc(1'b1, 1'b0);
    repeat (40) cyc(1'b1, 1'b1);
    repeat (40) cyc(1'b0, 1'b0);

    // three 32-sample frames then drain
    do_reset();
    clear_counts();
    stream(96, 40);
    check_stream_counts();

    // reset in the middle of a flush, then a fresh stream must match
    stream(40, 10);
    do_reset();
    clear_counts();
    stream(96, 40);
    check_stream_counts();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
